register_bank: RTL and testbench
================================

# register_bank

General-purpose register bank feeding the ALU's `dataA`/`dataB` operands and accepting its `dataC` result at writeback. Holds 32 × 32-bit registers with two combinational read ports and one synchronous write port. Write-to-read bypass lets an instruction see a value written in the same cycle. ALU `error` is gated here: a faulting result is never committed, and the fault is logged in a sticky flag and a saturating counter. A latched output register serves the Out opcode.

## Interface
- `DATA_WIDTH`, 32, register and port data width
- `ADDR_WIDTH`, 5, register index width; register count = 2**ADDR_WIDTH
- `ERR_CNT_WIDTH`, 8, error counter width
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clock`
- `readAddrA`  in  ADDR_WIDTH  index for port A
- `readAddrB`  in  ADDR_WIDTH  index for port B
- `dataA`  out  DATA_WIDTH  port A read data, to ALU `dataA`
- `dataB`  out  DATA_WIDTH  port B read data, to ALU `dataB`
- `writeEnable`  in  1  commit `writeData` to `writeAddr` this cycle
- `writeAddr`  in  ADDR_WIDTH  destination index
- `writeData`  in  DATA_WIDTH  result, from ALU `dataC`
- `aluError`  in  1  ALU `error` for the result being written
- `outEnable`  in  1  latch `writeData` into `outData` (Out opcode)
- `outData`  out  DATA_WIDTH  registered output port
- `errorClear`  in  1  clear sticky error flag and counter
- `errorFlag`  out  1  sticky: at least one write suppressed since clear or reset
- `errorCount`  out  ERR_CNT_WIDTH  number of suppressed writes, saturating

## Operation
- Register 0 is hardwired to zero. It always reads 0, and writes to it are ignored. Ignored writes to register 0 do not count as errors unless `aluError` = 1.
- Read port behaviour is identical for A and B:
  - If `writeEnable` = 1, `aluError` = 0, `writeAddr` = read address, and that address ≠ 0, the port returns `writeData` (bypass).
  - Otherwise the port returns the array content.
- Commit condition: `writeEnable` = 1, `aluError` = 0, `writeAddr` ≠ 0. The array entry updates at the clock edge.
- Suppressed write: `writeEnable` = 1 and `aluError` = 1.
  - The array is unchanged.
  - `errorFlag` is set to 1.
  - `errorCount` increments, saturating at 2**ERR_CNT_WIDTH − 1 with no wrap.
- `aluError` with `writeEnable` = 0 is ignored (no log).
- `outEnable` = 1 loads `outData` ← `writeData` regardless of `aluError`. It is independent of `writeEnable`.
- `errorClear` = 1 sets `errorFlag` to 0 and `errorCount` to 0.
  - If a suppressed write occurs in the same cycle, the error wins: `errorFlag` = 1 and `errorCount` = 1.
- Reset (`reset` = 0 at edge):
  - All registers = 0, `outData` = 0, `errorFlag` = 0, `errorCount` = 0.
  - Reset overrides every other input in that cycle, including a pending write.
  - While reset is held, reads return 0. The bypass is disabled during reset.

## Timing
- Read latency is 0 cycles: `dataA`/`dataB` are combinational from the address, array, and bypass inputs.
- Write latency is 1 cycle: the value is visible in the array after the edge. In the same cycle it is visible only via bypass.
- `outData`, `errorFlag`, and `errorCount` are registered and update 1 cycle after the inputs are sampled.
- Reset takes effect at the first rising edge with `reset` = 0. Outputs hold reset values from that edge until the first edge with `reset` = 1.
- There are no combinational paths from `errorClear` or `outEnable` to any output.

## Structure
- A shared package `core_pkg` holds:
  - `DATA_WIDTH`, `ADDR_WIDTH`, `REG_ZERO` = 0
  - The opcode constants used by the decoder and ALU (e.g. `OP_OUT` = 6'b011100, `OP_MOV` = 6'b011101)
- One sub-module, `sat_counter`:
  - Parameterised width.
  - Inputs: increment and clear.
  - Increment beats clear when both are asserted.
  - Saturates at all-ones.
  - Instantiated for `errorCount`.
- The register array and bypass muxes are inline.

## Test plan
- Reset, then read all 32 addresses on both ports → all return 0. `outData` = 0, `errorFlag` = 0, `errorCount` = 0.
- Write 0xDEADBEEF to r5 with `readAddrA` = 5 in the same cycle → `dataA` = 0xDEADBEEF that cycle (bypass). Next cycle with `writeEnable` = 0 → still 0xDEADBEEF.
- Write 0x12345678 to r0 → `dataA`/`dataB` at address 0 stay 0, both same cycle and after.
- r7 = 0x11. Write 0x99 to r7 with `aluError` = 1 → r7 stays 0x11, bypass not taken, `errorFlag` = 1, `errorCount` = 1. Repeat 300 suppressed writes → `errorCount` = 255.
- `errorClear` = 1 in the same cycle as a suppressed write → `errorFlag` = 1, `errorCount` = 1. `errorClear` alone next cycle → both 0.
- `outEnable` = 1 with `writeData` = 0xA5A5A5A5, then drive `reset` = 0 mid-stream together with `writeEnable` = 1 to r3 → `outData` = 0xA5A5A5A5 after the first edge. After the reset edge, `outData` = 0 and r3 = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants: datapath widths, the hardwired-zero register index and
// the opcode encodings used by the decoder and ALU.
package core_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned REG_ZERO   = 0;

  localparam logic [5:0] OP_OUT = 6'b011100;
  localparam logic [5:0] OP_MOV = 6'b011101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// An increment in the same cycle as a clear restarts the count at one.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (increment) begin
      if (clear) begin
        count_q <= WIDTH'(1);
      end else if (count_q != {WIDTH{1'b1}}) begin
        count_q <= count_q + WIDTH'(1);
      end
    end else if (clear) begin
      count_q <= '0;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/register_bank.sv
// General-purpose register bank: two combinational read ports with write bypass,
// one write port gated by the ALU error, error logging and a latched Out register.
module register_bank
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = core_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = core_pkg::ADDR_WIDTH,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    readAddrA,
  input  logic [ADDR_WIDTH-1:0]    readAddrB,
  output logic [DATA_WIDTH-1:0]    dataA,
  output logic [DATA_WIDTH-1:0]    dataB,
  input  logic                     writeEnable,
  input  logic [ADDR_WIDTH-1:0]    writeAddr,
  input  logic [DATA_WIDTH-1:0]    writeData,
  input  logic                     aluError,
  input  logic                     outEnable,
  output logic [DATA_WIDTH-1:0]    outData,
  input  logic                     errorClear,
  output logic                     errorFlag,
  output logic [ERR_CNT_WIDTH-1:0] errorCount
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] out_q;
  logic                  flag_q;
  logic                  commit;
  logic                  suppress;

  assign commit   = writeEnable && !aluError && (writeAddr != ZeroAddr);
  assign suppress = writeEnable && aluError;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[writeAddr] <= writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (outEnable) begin
        out_q <= writeData;
      end
      if (suppress) begin
        flag_q <= 1'b1;
      end else if (errorClear) begin
        flag_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clock     (clock),
    .reset     (reset),
    .increment (suppress),
    .clear     (errorClear),
    .count     (errorCount)
  );

  // Reads are forced to zero while reset is held, which also disables the bypass.
  always_comb begin
    dataA = '0;
    dataB = '0;
    if (reset) begin
      if (readAddrA == ZeroAddr) begin
        dataA = '0;
      end else if (commit && (writeAddr == readAddrA)) begin
        dataA = writeData;
      end else begin
        dataA = regs_q[readAddrA];
      end
      if (readAddrB == ZeroAddr) begin
        dataB = '0;
      end else if (commit && (writeAddr == readAddrB)) begin
        dataB = writeData;
      end else begin
        dataB = regs_q[readAddrB];
      end
    end
  end

  assign outData   = out_q;
  assign errorFlag = flag_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: expectations are queued as stimulus is
// driven and popped against the DUT outputs once they have settled.
module tb_register_bank;

  localparam int KA = 0, KB = 1, KOUT = 2, KFLAG = 3, KCNT = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  readAddrA, readAddrB, writeAddr;
  logic [31:0] dataA, dataB, writeData, outData;
  logic        writeEnable, aluError, outEnable, errorClear, errorFlag;
  logic [7:0]  errorCount;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] mem [32];
  logic [31:0] m_out;
  logic        m_flag;
  int          m_cnt;

  always #5 clock = ~clock;

  register_bank dut (
    .clock       (clock),
    .reset       (reset),
    .readAddrA   (readAddrA),
    .readAddrB   (readAddrB),
    .dataA       (dataA),
    .dataB       (dataB),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .aluError    (aluError),
    .outEnable   (outEnable),
    .outData     (outData),
    .errorClear  (errorClear),
    .errorFlag   (errorFlag),
    .errorCount  (errorCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input int kind, input string tag, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        KA:      obs = dataA;
        KB:      obs = dataB;
        KOUT:    obs = outData;
        KFLAG:   obs = {31'd0, errorFlag};
        default: obs = {24'd0, errorCount};
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    writeEnable = 1'b0;
    aluError    = 1'b0;
    outEnable   = 1'b0;
    errorClear  = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    writeEnable = 1'b1;
    writeAddr   = a;
    writeData   = d;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    readAddrA = '0; readAddrB = '0; writeAddr = '0; writeData = '0;
    idle();
    step();
    step();
    reset = 1'b1;

    // Reset state on both ports and registered outputs
    for (int i = 0; i < 32; i++) begin
      readAddrA = 5'(i);
      readAddrB = 5'(31 - i);
      expect_val(KA, $sformatf("rst_a%0d", i), 32'h0);
      expect_val(KB, $sformatf("rst_b%0d", 31 - i), 32'h0);
      drain();
    end
    expect_val(KOUT, "rst_out", 32'h0);
    expect_val(KFLAG, "rst_flag", 32'h0);
    expect_val(KCNT, "rst_cnt", 32'h0);
    drain();

    // Bypass, then array read
    writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
    readAddrA = 5'd5; readAddrB = 5'd6;
    expect_val(KA, "bypass_a", 32'hDEADBEEF);
    expect_val(KB, "bypass_other_b", 32'h0);
    drain();
    step();
    idle();
    readAddrB = 5'd5;
    expect_val(KA, "r5_a", 32'hDEADBEEF);
    expect_val(KB, "r5_b", 32'hDEADBEEF);
    drain();

    // Register 0 ignores writes
    writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'h12345678;
    readAddrA = 5'd0; readAddrB = 5'd0;
    expect_val(KA, "r0_same_a", 32'h0);
    expect_val(KB, "r0_same_b", 32'h0);
    drain();
    step();
    idle();
    expect_val(KA, "r0_after_a", 32'h0);
    expect_val(KB, "r0_after_b", 32'h0);
    expect_val(KCNT, "r0_no_err", 32'h0);
    drain();

    // Suppressed write keeps old value and logs the fault
    write(5'd7, 32'h11);
    writeEnable = 1'b1; aluError = 1'b1; writeAddr = 5'd7; writeData = 32'h99;
    readAddrA = 5'd7;
    expect_val(KA, "err_no_bypass", 32'h11);
    drain();
    step();
    idle();
    expect_val(KA, "err_r7_kept", 32'h11);
    expect_val(KFLAG, "err_flag", 32'h1);
    expect_val(KCNT, "err_cnt1", 32'h1);
    drain();
    aluError = 1'b1;
    step();
    expect_val(KCNT, "err_no_we", 32'h1);
    drain();
    for (int i = 0; i < 300; i++) begin
      writeEnable = 1'b1; aluError = 1'b1;
      step();
    end
    idle();
    expect_val(KCNT, "err_saturate", 32'd255);
    expect_val(KA, "err_r7_still", 32'h11);
    drain();

    // Error wins over clear; clear alone zeroes
    writeEnable = 1'b1; aluError = 1'b1; errorClear = 1'b1;
    step();
    idle();
    expect_val(KFLAG, "clr_err_flag", 32'h1);
    expect_val(KCNT, "clr_err_cnt", 32'h1);
    drain();
    errorClear = 1'b1;
    step();
    idle();
    expect_val(KFLAG, "clr_flag", 32'h0);
    expect_val(KCNT, "clr_cnt", 32'h0);
    drain();

    // Out latch, then reset overriding a pending write
    write(5'd3, 32'h33);
    outEnable = 1'b1; writeData = 32'hA5A5A5A5;
    step();
    idle();
    expect_val(KOUT, "out_latch", 32'hA5A5A5A5);
    drain();
    writeEnable = 1'b1; aluError = 1'b1; writeAddr = 5'd3; writeData = 32'h5;
    step();
    idle();
    expect_val(KOUT, "out_hold", 32'hA5A5A5A5);
    expect_val(KFLAG, "pre_rst_flag", 32'h1);
    drain();
    reset = 1'b0;
    writeEnable = 1'b1; writeAddr = 5'd3; writeData = 32'h77; readAddrA = 5'd3;
    outEnable = 1'b1;
    expect_val(KA, "rst_no_bypass", 32'h0);
    drain();
    step();
    reset = 1'b1;
    idle();
    expect_val(KA, "rst_r3", 32'h0);
    expect_val(KOUT, "rst_out2", 32'h0);
    expect_val(KFLAG, "rst_flag2", 32'h0);
    expect_val(KCNT, "rst_cnt2", 32'h0);
    drain();

    // Randomised traffic against a reference model
    for (int i = 0; i < 32; i++) mem[i] = '0;
    m_out = '0; m_flag = 1'b0; m_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      expect_val(KOUT, "rnd_out", m_out);
      expect_val(KFLAG, "rnd_flag", {31'd0, m_flag});
      expect_val(KCNT, "rnd_cnt", m_cnt);
      writeEnable = 1'($urandom_range(0, 1));
      aluError    = ($urandom_range(0, 3) == 0);
      outEnable   = ($urandom_range(0, 3) == 0);
      errorClear  = ($urandom_range(0, 7) == 0);
      writeAddr   = 5'($urandom_range(0, 7));
      writeData   = $urandom;
      readAddrA   = 5'($urandom_range(0, 7));
      readAddrB   = 5'($urandom_range(0, 7));
      expect_val(KA, "rnd_a",
                 (readAddrA == 0) ? 32'h0 :
                 (writeEnable && !aluError && writeAddr == readAddrA) ? writeData
                                                                      : mem[readAddrA]);
      expect_val(KB, "rnd_b",
                 (readAddrB == 0) ? 32'h0 :
                 (writeEnable && !aluError && writeAddr == readAddrB) ? writeData
                                                                      : mem[readAddrB]);
      drain();
      if (writeEnable && !aluError && writeAddr != 0) mem[writeAddr] = writeData;
      if (outEnable) m_out = writeData;
      if (writeEnable && aluError) begin
        m_flag = 1'b1;
        m_cnt  = errorClear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (errorClear) begin
        m_flag = 1'b0;
        m_cnt  = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
